pwm_capture: RTL

Measures an incoming servo-style PWM signal and reports its high time and period in microseconds, acting as the receive-side counterpart to the servo PWM generator. It lets the solar tracker read back a commanded servo pulse in closed loop, or read any PWM-output sensor, using the same 1 µs timebase as the generator. It sits beside the servo drivers and feeds measured widths to the tracking control logic.

---
 rtl/pwm_capture.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Servo-style PWM receiver: measures high time and rise-to-rise period in
// microseconds on a CLK_DIV-cycle timebase, with glitch rejection and timeout.
module pwm_capture #(
  parameter int CLK_DIV    = 100,
  parameter int MIN_WIDTH  = 500,
  parameter int MAX_WIDTH  = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PWM_IN,
  output logic [31:0] pulse_width,
  output logic [31:0] period,
  output logic        width_valid,
  output logic        period_valid,
  output logic        in_range,
  output logic        timeout
);

  localparam int          PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_US);
  localparam logic [31:0] MIN_W   = 32'(MIN_WIDTH);
  localparam logic [31:0] MAX_W   = 32'(MAX_WIDTH);

  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    sync_reg;
  logic [2:0]    fill_reg;
  logic [PW-1:0] presc_reg;
  logic [31:0]   hi_cnt_reg, per_cnt_reg;

  logic        s2, s3, rise, fall, tick, to_hit, range_ok;
  logic [31:0] hi_cap, per_cap;
  logic        load_width, load_period, set_timeout;

  // fill_reg marks when s2/s3 both hold real samples after reset, so a pulse
  // that was already high at reset release is never mistaken for a rise.
  assign s2   = sync_reg[1];
  assign s3   = sync_reg[2];
  assign rise = s2 & ~s3 & fill_reg[2];
  assign fall = ~s2 & s3 & fill_reg[2];
  assign tick = (presc_reg == PS_LAST);

  // Captured values include a tick landing in the same cycle, saturating.
  assign hi_cap   = hi_cnt_reg  + 32'(tick && (hi_cnt_reg  != TO_LIM));
  assign per_cap  = per_cnt_reg + 32'(tick && (per_cnt_reg != TO_LIM));
  assign to_hit   = (per_cnt_reg == TO_LIM);
  assign range_ok = (hi_cap >= MIN_W) && (hi_cap <= MAX_W);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_reg    <= '0;
      fill_reg    <= '0;
      presc_reg   <= '0;
      hi_cnt_reg  <= '0;
      per_cnt_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[1:0], PWM_IN};
      fill_reg  <= {fill_reg[1:0], 1'b1};
      presc_reg <= (rise || tick) ? '0 : presc_reg + 1'b1;
      if (rise) begin
        hi_cnt_reg  <= '0;
        per_cnt_reg <= '0;
      end else begin
        per_cnt_reg <= per_cap;
        if (state_reg == HIGH) hi_cnt_reg <= hi_cap;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_reg <= WAIT_RISE;
    else      state_reg <= state_next;
  end

  // Priority: rise, then timeout, then fall.
  always_comb begin
    state_next = state_reg;
    if (rise) begin
      state_next = HIGH;
    end else if (to_hit) begin
      state_next = WAIT_RISE;
    end else begin
      case (state_reg)
        HIGH:    if (fall) state_next = (hi_cap == '0) ? WAIT_RISE : LOW;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    load_width  = 1'b0;
    load_period = 1'b0;
    set_timeout = 1'b0;
    if (rise) begin
      load_period = (state_reg == LOW);
    end else if (to_hit) begin
      set_timeout = 1'b1;
    end else if ((state_reg == HIGH) && fall && (hi_cap != '0)) begin
      load_width = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pulse_width  <= '0;
      period       <= '0;
      width_valid  <= 1'b0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      width_valid  <= load_width;
      period_valid <= load_period;
      if (load_width) begin
        pulse_width <= hi_cap;
        in_range    <= range_ok;
      end
      if (load_period) period <= per_cap;
      if (rise) begin
        timeout <= 1'b0;
      end else if (set_timeout) begin
        timeout  <= 1'b1;
        in_range <= 1'b0;
      end
    end
  end

endmodule
